fp16_adder_tree_param: RTL and testbench
========================================

FP16_ADDER_TREE_PARAM -- requirements
Module: fp16_adder_tree_param

Interface
REQ-001 The block SHALL have parameter N_IN, default 49, meaning the number of FP16 operands per beat (legal range 2..64).
REQ-002 The block SHALL have parameter L, default $clog2(N_IN), a derived constant giving the tree depth and register-stage count; it SHALL NOT be overridden.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port en, input, 1 bit: global pipeline advance; when low, every register holds.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data holds a valid beat.
REQ-007 The block SHALL have port in_data, input, 16*N_IN bits: operand i at bits [16i+15:16i].
REQ-008 The block SHALL have port in_first, input, 1 bit: first beat of an accumulation group (used only with ACC_EN).
REQ-009 The block SHALL have port in_last, input, 1 bit: last beat of an accumulation group (used only with ACC_EN).
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_sum is valid; asserted for exactly one cycle per result.
REQ-011 The block SHALL have port out_sum, output, 16 bits: the FP16 result.
REQ-012 The block SHALL have port out_restart, output, 1 bit: one-cycle pulse when a partial group is discarded (ACC_EN only; otherwise tied to 0).

Function
REQ-013 Each tree level SHALL add adjacent pairs (2j, 2j+1) using the existing combinational FP_Add_16, then register the results.
REQ-014 At a level with an odd element count, the last element SHALL be forwarded unmodified through that level's register.
REQ-015 The tree SHALL have exactly L register levels; the tree result SHALL be valid L cycles (en=1) after the in_valid beat.
REQ-016 in_valid, in_first and in_last SHALL travel alongside the data as an L-deep tag shift register advancing only when en=1.
REQ-017 Data registers SHALL load every enabled cycle regardless of valid; only the valid tag qualifies the output.
REQ-018 The block SHALL accept one beat per enabled cycle, with no backpressure; en=0 SHALL freeze data, tags, accumulator and FSM state.
REQ-019 Outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Reset
REQ-020 While rst is high, all tree registers, all tags, out_sum, out_valid, out_restart and the accumulator SHALL be 0, and the FSM SHALL be in IDLE.
REQ-021 rst asserted mid-operation SHALL discard every in-flight beat and partial group; no out_valid SHALL follow for beats accepted before reset.
REQ-022 The first beat accepted in the cycle after rst deasserts SHALL be processed normally.

Configuration
REQ-023 With macro FP16_TREE_ACC_EN undefined, out_sum/out_valid SHALL be the tree output and its valid tag registered once (latency L+1), in_first and in_last SHALL be ignored, and out_restart SHALL be 0.
REQ-024 With FP16_TREE_ACC_EN defined, a second FP_Add_16 SHALL accumulate tree results across beats, controlled by a two-state FSM (IDLE, ACCUM).
REQ-025 On a tree-valid beat with first=1, acc SHALL load the tree sum; on one with first=0 in ACCUM, acc SHALL become acc + tree sum.
REQ-026 IDLE->ACCUM SHALL occur on a valid first beat with last=0; ACCUM->IDLE SHALL occur on a valid last beat.
REQ-027 On a valid last beat, out_sum SHALL present the final accumulated value with out_valid=1 in the next cycle (latency L+1 from the last beat).
REQ-028 A beat with first=1 and last=1 SHALL form a single-beat group and output its tree sum.
REQ-029 A valid first beat arriving in ACCUM SHALL restart the group with that beat and pulse out_restart.
REQ-030 A valid beat with first=0 arriving in IDLE SHALL be dropped, producing no output and no state change.

Verification
REQ-031 N_IN=49, one beat of 49 x 0x3C00 (1.0), ACC_EN off -> out_sum=0x5220 (49.0) with out_valid 7 cycles later.
REQ-032 N_IN=8, all operands 0x4000 (2.0) -> out_sum=0x4C00 (16.0) after 4 cycles; all operands 0x0000 -> out_sum=0x0000.
REQ-033 ACC_EN, N_IN=49, three back-to-back beats of all 1.0 with first on beat 0 and last on beat 2 -> a single out_valid with out_sum=0x5898 (147.0).
REQ-034 Stream of 10 back-to-back beats with en held low for 3 cycles mid-stream -> 10 correct results in order, with out_valid gaps matching exactly the 3 stalled cycles.
REQ-035 ACC_EN, first beat, then a second first beat before last -> one out_restart pulse; the final result equals the sum of the second group only.
REQ-036 rst pulsed while 4 beats are in flight -> all outputs 0 during rst and no out_valid for those beats; the next beat returns the correct result.

Source files
------------

// File: rtl/fp16_adder_tree_param.sv
// FP16 pipelined adder tree: sums N_IN half-precision operands per beat.
// Each level adds adjacent pairs and registers them; an odd leftover is forwarded.
// Optional cross-beat accumulation is enabled by defining FP16_TREE_ACC_EN.

// Combinational FP16 adder with round-to-nearest-even.
// Subnormals are handled. Inf/NaN operands are not special-cased.
module FP_Add_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic [15:0] x, z;
    logic [4:0]  ex, ez, d;
    logic [13:0] ax, az;
    logic [14:0] s;
    logic [5:0]  er;
    logic [11:0] mr;
    logic        rnd;

    // Align, add, normalise, round; x is always the larger magnitude
    always_comb begin
        if (a[14:0] >= b[14:0]) begin
            x = a;
            z = b;
        end else begin
            x = b;
            z = a;
        end
        ex = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
        ez = (z[14:10] == 5'd0) ? 5'd1 : z[14:10];
        d  = ex - ez;
        ax = {|x[14:10], x[9:0], 3'b000};
        az = {|z[14:10], z[9:0], 3'b000};
        // shift right one place at a time, jamming lost bits into the sticky LSB
        for (int unsigned i = 0; i < 16; i++) begin
            if (i < {27'd0, d})
                az = {1'b0, az[13:2], az[1] | az[0]};
        end
        s  = (x[15] == z[15]) ? ({1'b0, ax} + {1'b0, az}) : ({1'b0, ax} - {1'b0, az});
        er = {1'b0, ex};
        if (s[14]) begin
            s  = {1'b0, s[14:2], s[1] | s[0]};
            er = er + 6'd1;
        end else begin
            for (int unsigned i = 0; i < 13; i++) begin
                if (!s[13] && er > 6'd1) begin
                    s  = s << 1;
                    er = er - 6'd1;
                end
            end
        end
        rnd = s[2] & (s[1] | s[0] | s[3]);
        mr  = {1'b0, s[13:3]} + {11'd0, rnd};
        if (mr[11]) begin
            mr = {1'b0, mr[11:1]};
            er = er + 6'd1;
        end
        if (er >= 6'd31)
            y = {x[15], 5'h1f, 10'd0};
        else if (mr == 12'd0)
            y = '0;
        else
            y = {x[15], mr[10] ? er[4:0] : 5'd0, mr[9:0]};
    end
endmodule

module fp16_adder_tree_param #(
    parameter int N_IN = 49,
    parameter int L    = $clog2(N_IN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    input  logic [16*N_IN-1:0] in_data,
    input  logic               in_first,
    input  logic               in_last,
    output logic               out_valid,
    output logic [15:0]        out_sum,
    output logic               out_restart
);
    function automatic int level_cnt(input int k);
        int n;
        n = N_IN;
        for (int i = 0; i < k; i++) n = (n + 1) / 2;
        return n;
    endfunction

    for (genvar k = 0; k <= L; k++) begin : lvl
        logic [15:0] q [0:N_IN-1];
        if (k == 0) begin : g_in
            for (genvar j = 0; j < N_IN; j++) begin : g_op
                assign q[j] = in_data[16*j +: 16];
            end
        end else begin : g_stage
            logic [15:0] d [0:N_IN-1];
            for (genvar j = 0; j < N_IN; j++) begin : g_node
                if (2*j + 1 < level_cnt(k-1)) begin : g_add
                    FP_Add_16 u_add (.a(lvl[k-1].q[2*j]), .b(lvl[k-1].q[2*j+1]), .y(d[j]));
                end else if (2*j < level_cnt(k-1)) begin : g_fwd
                    assign d[j] = lvl[k-1].q[2*j];
                end else begin : g_pad
                    assign d[j] = '0;
                end
            end
            // Level register: loads every enabled cycle, valid is carried by the tags
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned i = 0; i < N_IN; i++) q[i] <= '0;
                end else if (en) begin
                    for (int unsigned i = 0; i < N_IN; i++) q[i] <= d[i];
                end
            end
        end
    end

    logic [15:0] tree_sum;
    logic [L-1:0] vld_sr;
    assign tree_sum = lvl[L].q[0];

    // Valid tag travels alongside the data levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_sr <= '0;
        else if (en)
            vld_sr <= (vld_sr << 1) | L'(in_valid);
    end

`ifdef FP16_TREE_ACC_EN
    typedef enum logic {IDLE, ACCUM} state_t;
    state_t       state;
    logic [L-1:0] fst_sr, lst_sr;
    logic [15:0]  acc, acc_sum;

    FP_Add_16 u_acc (.a(acc), .b(tree_sum), .y(acc_sum));

    // Group-boundary tags travel alongside the data levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fst_sr <= '0;
            lst_sr <= '0;
        end else if (en) begin
            fst_sr <= (fst_sr << 1) | L'(in_first);
            lst_sr <= (lst_sr << 1) | L'(in_last);
        end
    end

    // Group accumulator FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            out_sum     <= '0;
            out_valid   <= 1'b0;
            out_restart <= 1'b0;
        end else if (en) begin
            out_valid   <= 1'b0;
            out_restart <= 1'b0;
            if (vld_sr[L-1]) begin
                if (fst_sr[L-1]) begin
                    out_restart <= (state == ACCUM);
                    acc         <= tree_sum;
                    if (lst_sr[L-1]) begin
                        out_sum   <= tree_sum;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        state <= ACCUM;
                    end
                end else if (state == ACCUM) begin
                    acc <= acc_sum;
                    if (lst_sr[L-1]) begin
                        out_sum   <= acc_sum;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
            end
        end else begin
            out_valid   <= 1'b0;
            out_restart <= 1'b0;
        end
    end
`else
    logic unused_tags;
    assign unused_tags = &{1'b0, in_first, in_last};
    assign out_restart = 1'b0;

    // Output register: tree result plus its valid tag; valid pulses only on enabled cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sum   <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            out_sum   <= tree_sum;
            out_valid <= vld_sr[L-1];
        end else begin
            out_valid <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_fp16_adder_tree_param.sv
// Directed bench for fp16_adder_tree_param (N_IN=49 and N_IN=8 instances).
module tb_fp16_adder_tree_param;
    localparam int NA    = 49;
    localparam int NB    = 8;
    localparam int LAT_A = $clog2(NA) + 1;
    localparam int LAT_B = $clog2(NB) + 1;
    localparam logic [15:0] ONE = 16'h3C00;

    logic clk = 1'b0;
    logic rst, en;
    logic a_valid, a_first, a_last, a_ovalid, a_restart;
    logic [16*NA-1:0] a_data;
    logic [15:0] a_sum;
    logic b_valid, b_first, b_last, b_ovalid, b_restart;
    logic [16*NB-1:0] b_data;
    logic [15:0] b_sum;

    fp16_adder_tree_param #(.N_IN(NA)) dut_a (
        .clk(clk), .rst(rst), .en(en), .in_valid(a_valid), .in_data(a_data),
        .in_first(a_first), .in_last(a_last), .out_valid(a_ovalid),
        .out_sum(a_sum), .out_restart(a_restart)
    );
    fp16_adder_tree_param #(.N_IN(NB)) dut_b (
        .clk(clk), .rst(rst), .en(en), .in_valid(b_valid), .in_data(b_data),
        .in_first(b_first), .in_last(b_last), .out_valid(b_ovalid),
        .out_sum(b_sum), .out_restart(b_restart)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int a_issue, b_issue, issue0, t;
    int ts [10];
    int a_rs = 0;
    int b_rs = 0;
    logic [15:0] a_q [$];
    int a_t [$];
    logic [15:0] b_q [$];
    int b_t [$];
    logic [15:0] stream_exp [10] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
                                     16'h4600, 16'h4700, 16'h4800, 16'h4880, 16'h4900};

    // Output monitor, sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (a_ovalid) begin a_q.push_back(a_sum); a_t.push_back(cyc); end
        if (b_ovalid) begin b_q.push_back(b_sum); b_t.push_back(cyc); end
        if (a_restart) a_rs++;
        if (b_restart) b_rs++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic beat_a(input int lo, input int n, input logic [15:0] v, input logic f, input logic l);
        @(negedge clk);
        for (int i = 0; i < NA; i++) a_data[16*i +: 16] = (i >= lo && i < lo + n) ? v : 16'h0000;
        a_valid = 1'b1; a_first = f; a_last = l;
        a_issue = cyc;
    endtask

    task automatic idle_a();
        @(negedge clk);
        a_valid = 1'b0; a_first = 1'b0; a_last = 1'b0;
    endtask

    task automatic beat_b(input logic [15:0] lo, input logic [15:0] hi);
        @(negedge clk);
        for (int i = 0; i < NB; i++) b_data[16*i +: 16] = (i < NB/2) ? lo : hi;
        b_valid = 1'b1;
        b_issue = cyc;
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    task automatic get_a(input string tag, input logic [15:0] exp, output int tm);
        int n = 0;
        while (a_q.size() == 0 && n < 40) begin @(negedge clk); n++; end
        if (a_q.size() == 0) begin
            checks++; errors++; tm = -1;
            $display("FAIL %s: no out_valid within 40 cycles, expected sum %h", tag, exp);
        end else begin
            tm = a_t.pop_front();
            check_eq(tag, 32'(a_q.pop_front()), 32'(exp));
        end
    endtask

    task automatic get_b(input string tag, input logic [15:0] exp, output int tm);
        int n = 0;
        while (b_q.size() == 0 && n < 40) begin @(negedge clk); n++; end
        if (b_q.size() == 0) begin
            checks++; errors++; tm = -1;
            $display("FAIL %s: no out_valid within 40 cycles, expected sum %h", tag, exp);
        end else begin
            tm = b_t.pop_front();
            check_eq(tag, 32'(b_q.pop_front()), 32'(exp));
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1;
        a_valid = 1'b0; a_first = 1'b0; a_last = 1'b0; a_data = '0;
        b_valid = 1'b0; b_first = 1'b1; b_last = 1'b1; b_data = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_sum_a", 32'(a_sum), 32'h0);
        check_eq("reset_valid_a", 32'(a_ovalid), 32'h0);
        check_eq("reset_sum_b", 32'(b_sum), 32'h0);
        rst = 1'b0;

        // single beat, 49 x 1.0
        beat_a(0, NA, ONE, 1'b1, 1'b1); issue0 = a_issue; idle_a();
        get_a("sum49_ones", 16'h5220, t);
        check_eq("latency49", 32'(t - issue0), 32'(LAT_A));

        // only the last (odd, forwarded) operand non-zero
        beat_a(NA-1, 1, 16'h4500, 1'b1, 1'b1); idle_a();
        get_a("odd_forward", 16'h4500, t);

        // N_IN=8 instance
        beat_b(16'h4000, 16'h4000);
        get_b("sum8_twos", 16'h4C00, t);
        check_eq("latency8", 32'(t - b_issue), 32'(LAT_B));
        beat_b(16'h0000, 16'h0000); get_b("sum8_zero", 16'h0000, t);
        beat_b(16'h3800, 16'h3800); get_b("sum8_halves", 16'h4400, t);
        beat_b(16'hC000, 16'hC000); get_b("sum8_neg", 16'hCC00, t);
        beat_b(16'h3C00, 16'hBC00); get_b("sum8_cancel", 16'h0000, t);

        // 10-beat stream, 3-cycle stall while results are emerging
        for (int k = 0; k < 10; k++) begin
            beat_a(0, k + 1, ONE, 1'b1, 1'b1);
            if (k == 0) issue0 = a_issue;
        end
        @(negedge clk); a_valid = 1'b0; en = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk); en = 1'b1;
        for (int k = 0; k < 10; k++) get_a($sformatf("stream%0d", k), stream_exp[k], ts[k]);
        check_eq("stream_latency", 32'(ts[0] - issue0), 32'(LAT_A));
        check_eq("stream_gap", 32'(ts[4] - ts[3]), 32'd4);
        check_eq("stream_span", 32'(ts[9] - ts[0]), 32'd12);

        // reset with 4 beats in flight
        for (int k = 0; k < 4; k++) beat_a(0, k + 1, ONE, 1'b1, 1'b1);
        @(negedge clk); a_valid = 1'b0; rst = 1'b1; #1;
        check_eq("midrst_sum", 32'(a_sum), 32'h0);
        check_eq("midrst_valid", 32'(a_ovalid), 32'h0);
        check_eq("midrst_restart", 32'(a_restart), 32'h0);
        repeat (2) @(negedge clk); rst = 1'b0;
        beat_a(0, 7, ONE, 1'b1, 1'b1); issue0 = a_issue; idle_a();
        get_a("post_rst_sum", 16'h4700, t);
        check_eq("post_rst_latency", 32'(t - issue0), 32'(LAT_A));
        repeat (12) @(negedge clk);
        check_eq("rst_flush", 32'(a_q.size()), 32'h0);

`ifdef FP16_TREE_ACC_EN
        beat_a(0, NA, ONE, 1'b1, 1'b0);
        beat_a(0, NA, ONE, 1'b0, 1'b0);
        beat_a(0, NA, ONE, 1'b0, 1'b1); idle_a();
        get_a("acc3_sum", 16'h5898, t);
        repeat (12) @(negedge clk);
        check_eq("acc3_single", 32'(a_q.size()), 32'h0);

        beat_a(0, NA, ONE, 1'b1, 1'b0);
        beat_a(0, 2, ONE, 1'b1, 1'b0);
        beat_a(0, 3, ONE, 1'b0, 1'b1); idle_a();
        get_a("restart_sum", 16'h4500, t);

        beat_a(0, 5, ONE, 1'b0, 1'b1); idle_a();
        repeat (15) @(negedge clk);
        check_eq("idle_drop", 32'(a_q.size()), 32'h0);
        check_eq("restart_pulses", 32'(a_rs), 32'd1);
`else
        check_eq("no_restart", 32'(a_rs), 32'd0);
`endif
        check_eq("b_no_restart", 32'(b_rs), 32'd0);
        check_eq("b_no_stray", 32'(b_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
